// File: rtl/dynamic_dequantization_if.sv
// Stream bundle for the dequantizer: packed-lane input word with per-word
// precision/scale/shift, and a one-value-per-cycle int32 output stream.
interface dynamic_dequantization_if #(
  parameter int unsigned SCALE_W = 16,
  parameter int unsigned SHIFT_W = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               in_data;
  logic [15:0]               in_precision;
  logic signed [SCALE_W-1:0] in_scale;
  logic [SHIFT_W-1:0]        in_shift;
  logic                      out_valid;
  logic                      out_ready;
  logic [31:0]               out_data;
  logic                      out_last;
  logic                      err;

  modport master (
    output in_valid, in_data, in_precision, in_scale, in_shift, out_ready,
    input  in_ready, out_valid, out_data, out_last, err
  );

  modport slave (
    input  in_valid, in_data, in_precision, in_scale, in_shift, out_ready,
    output in_ready, out_valid, out_data, out_last, err
  );
endinterface

// File: rtl/dynamic_dequantization.sv
// Streaming dequantizer: unpacks int32/int16/int8 lanes from a word, scales,
// rounds, shifts and saturates each lane to int32, one lane per cycle.
module dynamic_dequantization #(
  parameter int unsigned SCALE_W = 16,
  parameter int unsigned SHIFT_W = 5
) (
  input logic                     clk,
  input logic                     rst,
  dynamic_dequantization_if.slave bus
);
  localparam int unsigned ProdW = 32 + SCALE_W;

  typedef enum logic [0:0] {StIdle, StUnpack} state_e;

  state_e                    r_state, w_state_d;
  logic [31:0]               r_data;
  logic [1:0]                r_last_idx;
  logic signed [SCALE_W-1:0] r_scale;
  logic [SHIFT_W-1:0]        r_shift;
  logic [1:0]                r_lane, w_lane_d;
  logic                      r_out_valid, w_out_valid_d;
  logic [31:0]               r_out_data, w_out_data_d;
  logic                      r_out_last, w_out_last_d;
  logic                      r_err, w_err_d;

  logic                      w_prec_ok;
  logic [1:0]                w_prec_last_idx;
  logic                      w_in_ready, w_fire, w_accept, w_out_free, w_load, w_is_last;
  logic                      w_from_input;
  logic [31:0]               w_src_data;
  logic [1:0]                w_src_last_idx, w_src_lane;
  logic signed [SCALE_W-1:0] w_src_scale;
  logic [SHIFT_W-1:0]        w_src_shift;
  logic signed [31:0]        w_x;
  logic signed [ProdW-1:0]   w_prod, w_half, w_rnd, w_shr;
  logic [31:0]               w_res;

  // Lane count is kept as the index of the last lane: 0/1/3 for int32/int16/int8.
  always_comb begin
    w_prec_ok       = 1'b1;
    w_prec_last_idx = 2'd0;
    case (bus.in_precision)
      16'h0001: w_prec_last_idx = 2'd0;
      16'h0002: w_prec_last_idx = 2'd1;
      16'h0004: w_prec_last_idx = 2'd3;
      default:  w_prec_ok       = 1'b0;
    endcase
  end

  assign w_out_free   = !r_out_valid || bus.out_ready;
  assign w_from_input = (r_state == StIdle);
  assign w_in_ready   = !rst && (w_from_input || (w_out_free && (r_lane == r_last_idx)));
  assign w_fire       = bus.in_valid && w_in_ready;
  assign w_accept     = w_fire && w_prec_ok;

  // In IDLE, lane 0 of an arriving word bypasses the buffer for one-cycle latency.
  always_comb begin
    w_src_data     = r_data;
    w_src_last_idx = r_last_idx;
    w_src_lane     = r_lane;
    w_src_scale    = r_scale;
    w_src_shift    = r_shift;
    w_load         = w_out_free;
    if (w_from_input) begin
      w_src_data     = bus.in_data;
      w_src_last_idx = w_prec_last_idx;
      w_src_lane     = 2'd0;
      w_src_scale    = bus.in_scale;
      w_src_shift    = bus.in_shift;
      w_load         = w_accept && w_out_free;
    end
  end

  assign w_is_last = (w_src_lane == w_src_last_idx);

  always_comb begin
    unique case (w_src_last_idx)
      2'd0:    w_x = w_src_data;
      2'd1:    w_x = 32'($signed(w_src_data[{w_src_lane[0], 4'b0000} +: 16]));
      default: w_x = 32'($signed(w_src_data[{w_src_lane, 3'b000} +: 8]));
    endcase
  end

  always_comb begin
    w_prod = w_x * w_src_scale;
    w_half = ProdW'(1) << (w_src_shift - 1'b1);
    w_rnd  = (w_src_shift != '0) ? (w_prod + w_half) : w_prod;
    w_shr  = w_rnd >>> w_src_shift;
    if ((w_shr[ProdW-1:31] == '0) || (w_shr[ProdW-1:31] == '1)) begin
      w_res = w_shr[31:0];
    end else begin
      w_res = w_shr[ProdW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_lane_d      = r_lane;
    w_out_valid_d = r_out_valid;
    w_out_data_d  = r_out_data;
    w_out_last_d  = r_out_last;
    w_err_d       = w_fire && !w_prec_ok;
    if (w_load) begin
      w_out_valid_d = 1'b1;
      w_out_data_d  = w_res;
      w_out_last_d  = w_is_last;
    end else if (bus.out_ready) begin
      w_out_valid_d = 1'b0;
    end
    unique case (r_state)
      StIdle: begin
        if (w_accept && !(w_load && w_is_last)) begin
          w_state_d = StUnpack;
          w_lane_d  = w_load ? 2'd1 : 2'd0;
        end
      end
      StUnpack: begin
        if (w_load) begin
          if (w_is_last) begin
            w_state_d = w_accept ? StUnpack : StIdle;
            w_lane_d  = 2'd0;
          end else begin
            w_lane_d = r_lane + 2'd1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_lane      <= 2'd0;
      r_data      <= '0;
      r_last_idx  <= 2'd0;
      r_scale     <= '0;
      r_shift     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_lane      <= w_lane_d;
      r_out_valid <= w_out_valid_d;
      r_out_data  <= w_out_data_d;
      r_out_last  <= w_out_last_d;
      r_err       <= w_err_d;
      if (w_accept) begin
        r_data     <= bus.in_data;
        r_last_idx <= w_prec_last_idx;
        r_scale    <= bus.in_scale;
        r_shift    <= bus.in_shift;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_dynamic_dequantization.sv
// Bench for dynamic_dequantization: directed cases plus randomized words checked
// every cycle against a queue-based arithmetic model of the lane outputs.
module tb_dynamic_dequantization;
  localparam int unsigned SCALE_W = 16;
  localparam int unsigned SHIFT_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;

  dynamic_dequantization_if #(.SCALE_W(SCALE_W), .SHIFT_W(SHIFT_W)) bus ();

  dynamic_dequantization #(.SCALE_W(SCALE_W), .SHIFT_W(SHIFT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  logic [32:0] q[$];
  logic [31:0] log_d[$];
  bit          log_l[$];
  int          log_c[$];
  int          acc_cyc = 0;
  bit          err_exp = 1'b0;
  bit          rand_ready = 1'b0;
  bit          fixed_ready = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  function automatic int lanes_of(input logic [15:0] p);
    if (p == 16'h0001) return 1;
    if (p == 16'h0002) return 2;
    if (p == 16'h0004) return 4;
    return 0;
  endfunction

  // Reference arithmetic in 64-bit integers.
  function automatic logic [31:0] deq(input logic [31:0] d, input int n, input int k,
                                      input logic signed [SCALE_W-1:0] sc, input int sh);
    longint x;
    longint p;
    if (n == 1) x = longint'($signed(d));
    else if (n == 2) x = longint'($signed(d[16*k +: 16]));
    else x = longint'($signed(d[8*k +: 8]));
    p = x * longint'(sc);
    if (sh > 0) p = p + (longint'(1) <<< (sh - 1));
    p = p >>> sh;
    if (p > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    if (p < -64'sh8000_0000) return 32'h8000_0000;
    return p[31:0];
  endfunction

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_ready ? ($urandom_range(3) != 0) : fixed_ready;
    end
  end

  // Per-cycle compare against the model queue.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
      q.delete();
      err_exp = 1'b0;
    end else begin
      chk("err", 32'(bus.err), 32'(err_exp));
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          chk("out_data", bus.out_data, q[0][31:0]);
          chk("out_last", 32'(bus.out_last), 32'(q[0][32]));
          if (bus.out_ready) begin
            log_d.push_back(bus.out_data);
            log_l.push_back(bus.out_last);
            log_c.push_back(cycle);
            void'(q.pop_front());
          end
        end
      end
      err_exp = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        int n;
        n = lanes_of(bus.in_precision);
        acc_cyc = cycle;
        if (n == 0) err_exp = 1'b1;
        for (int k = 0; k < n; k++) begin
          q.push_back({(k == n - 1),
                       deq(bus.in_data, n, k, bus.in_scale, int'(bus.in_shift))});
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic [15:0] p,
                           input logic [SCALE_W-1:0] sc, input logic [SHIFT_W-1:0] sh,
                           input bit keep);
    bit ok = 1'b0;
    bus.in_valid     = 1'b1;
    bus.in_data      = d;
    bus.in_precision = p;
    bus.in_scale     = sc;
    bus.in_shift     = sh;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    chk("send_accepted", 32'(ok), 32'd1);
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.out_valid) break;
    end
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_d.delete();
    log_l.delete();
    log_c.delete();
  endtask

  task automatic set_ready(input bit v);
    fixed_ready = v;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_log(input string name, input int n, input logic [255:0] e,
                         input logic [7:0] l);
    chk({name, "_count"}, 32'(log_d.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (k < log_d.size()) begin
        chk({name, "_data"}, log_d[k], e[32*k +: 32]);
        chk({name, "_last"}, 32'(log_l[k]), 32'(l[k]));
      end
    end
  endtask

  task automatic chk_no_bubble(input string name);
    for (int k = 1; k < log_c.size(); k++) chk(name, 32'(log_c[k] - log_c[k-1]), 32'd1);
  endtask

  initial begin
    int acc;
    int gap;
    int gap_next;
    logic [15:0] p;
    logic [15:0] sc;
    logic [31:0] d;

    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.in_precision = '0;
    bus.in_scale     = '0;
    bus.in_shift     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_data", bus.out_data, 32'd0);
    chk("reset_out_last", 32'(bus.out_last), 32'd0);
    chk("reset_err", 32'(bus.err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    chk("model_round", deq(32'h0000_00FD, 4, 0, 16'sd1, 1), 32'hFFFF_FFFF);
    chk("model_sat_hi", deq(32'h7FFF_FFFF, 1, 0, 16'sh7FFF, 0), 32'h7FFF_FFFF);
    chk("model_sat_lo", deq(32'h8000_0000, 1, 0, 16'sd2, 0), 32'h8000_0000);
    chk("model_int16", deq(32'h8000_7FFF, 2, 1, 16'sd2, 1), 32'hFFFF_8000);
    @(posedge clk);
    #1;

    // int8 lanes, latency and throughput
    clear_log();
    send_word(32'h80FF_7F01, 16'h0004, 16'd1, 5'd0, 1'b0);
    acc = acc_cyc;
    drain();
    chk_log("t1", 4, {128'h0, 32'hFFFF_FF80, 32'hFFFF_FFFF, 32'h0000_007F, 32'h0000_0001},
            8'b0000_1000);
    if (log_c.size() > 0) chk("t1_latency", 32'(log_c[0]), 32'(acc + 1));
    chk_no_bubble("t1_gap");

    clear_log();
    send_word(32'h8000_7FFF, 16'h0002, 16'd2, 5'd1, 1'b0);
    drain();
    chk_log("t2", 2, {192'h0, 32'hFFFF_8000, 32'h0000_7FFF}, 8'b0000_0010);

    // saturation and rounding
    clear_log();
    send_word(32'h7FFF_FFFF, 16'h0001, 16'h7FFF, 5'd0, 1'b1);
    send_word(32'h8000_0000, 16'h0001, 16'd2, 5'd0, 1'b1);
    send_word(32'h0000_00FD, 16'h0004, 16'd1, 5'd1, 1'b0);
    drain();
    chk_log("t3", 6, {64'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF},
            8'b0010_0011);

    // backpressure
    set_ready(1'b0);
    clear_log();
    send_word(32'h0403_0201, 16'h0004, 16'd1, 5'd0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_hold_data", bus.out_data, 32'h0000_0001);
      chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
    end
    fixed_ready = 1'b1;
    drain();
    chk_log("t4", 4, {128'h0, 32'h4, 32'h3, 32'h2, 32'h1}, 8'b0000_1000);

    // back-to-back int16 words
    set_ready(1'b1);
    clear_log();
    send_word(32'h0002_0001, 16'h0002, 16'd1, 5'd0, 1'b1);
    send_word(32'hFFFF_0003, 16'h0002, 16'd1, 5'd0, 1'b0);
    drain();
    chk_log("t5", 4, {128'h0, 32'hFFFF_FFFF, 32'h3, 32'h2, 32'h1}, 8'b0000_1010);
    chk_no_bubble("t5_gap");

    // unsupported precision
    clear_log();
    send_word(32'h1234_5678, 16'h0003, 16'd1, 5'd0, 1'b0);
    @(negedge clk);
    chk("t6_err", 32'(bus.err), 32'd1);
    chk("t6_no_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("t6_err_pulse", 32'(bus.err), 32'd0);
    chk("t6_no_valid2", 32'(bus.out_valid), 32'd0);
    chk("t6_no_output", 32'(log_d.size()), 32'd0);
    @(posedge clk);
    #1;

    // reset mid-word
    send_word(32'h4433_2211, 16'h0004, 16'd1, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("t6_lane1", bus.out_data, 32'h0000_0022);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    clear_log();
    send_word(32'h0807_0605, 16'h0004, 16'd1, 5'd0, 1'b0);
    drain();
    chk_log("t6b", 4, {128'h0, 32'h8, 32'h7, 32'h6, 32'h5}, 8'b0000_1000);

    // randomized traffic with random backpressure
    rand_ready = 1'b1;
    gap = 0;
    for (int i = 0; i < 300; i++) begin
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      gap_next = ($urandom_range(2) == 0) ? 0 : $urandom_range(2);
      case ($urandom_range(9))
        0, 1, 2: p = 16'h0004;
        3, 4, 5: p = 16'h0002;
        6, 7:    p = 16'h0001;
        8:       p = 16'h0003;
        default: p = 16'($urandom);
      endcase
      sc = ($urandom_range(3) == 0) ? (($urandom_range(1) == 0) ? 16'h7FFF : 16'h8000)
                                    : 16'($urandom);
      d  = ($urandom_range(5) == 0) ? 32'h8000_0080 : $urandom;
      send_word(d, p, sc, 5'($urandom), (gap_next == 0));
      gap = gap_next;
    end
    bus.in_valid = 1'b0;
    rand_ready = 1'b0;
    fixed_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
